// File: rtl/ps2_tx.sv
// ps2_tx: PS/2 host-to-device command transmitter (inhibit, start, 8 data, odd parity, stop, ACK)
//   clock, reset      : system clock, synchronous active-high reset
//   start, tx_data    : one-cycle send request and the byte to send (ignored while busy)
//   busy              : transaction in progress, low in the done cycle
//   done              : one-cycle pulse ending every transaction
//   ack_ok, timeout   : status, valid while done=1
//   ps_clock_in/_data_in : raw pad levels
//   ps_clock_oe/_data_oe : 1 = pull the matching pad low (registered)
//   Optional macro PS2_TX_FILTER_EN adds a FILTER_LEN-sample glitch filter on the device clock.
module ps2_tx #(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int TIMEOUT_CYCLES = 375000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx_data,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       timeout,
  input  logic       ps_clock_in,
  input  logic       ps_data_in,
  output logic       ps_clock_oe,
  output logic       ps_data_oe
);
  localparam int CW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, BITS, ACK, WAIT_IDLE, DONE} state_t;
  state_t          r_state, w_state_n;
  logic [CW-1:0]   r_cnt, w_cnt_n;
  logic [TW-1:0]   r_tcnt, w_tcnt_n;
  logic [9:0]      r_shift, w_shift_n;
  logic [3:0]      r_bitcnt, w_bitcnt_n;
  logic            r_ack, w_ack_n;
  logic            r_to, w_to_n;
  logic            r_clk_oe, w_clk_oe_n;
  logic            r_dat_oe, w_dat_oe_n;
  logic [1:0]      r_clk_s, r_dat_s;
  logic            r_clk_prev;
  logic            w_clk_f, w_fall, w_tick;
`ifdef PS2_TX_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);
  logic          r_filt;
  logic [FW-1:0] r_fcnt;
  // filtered level flips only after FILTER_LEN consecutive samples disagree with it
  always_ff @(posedge clock) begin
    if (reset) begin
      r_filt <= 1'b1;
      r_fcnt <= '0;
    end else if (r_clk_s[1] == r_filt) begin
      r_fcnt <= '0;
    end else if (r_fcnt == FW'(FILTER_LEN - 1)) begin
      r_filt <= r_clk_s[1];
      r_fcnt <= '0;
    end else begin
      r_fcnt <= r_fcnt + FW'(1);
    end
  end
  assign w_clk_f = r_filt;
`else
  logic w_unused_flen;
  assign w_unused_flen = (FILTER_LEN > 0);
  assign w_clk_f = r_clk_s[1];
`endif
  assign w_fall  = r_clk_prev & ~w_clk_f;
  assign w_tick  = (r_state == RTS) || (r_state == BITS) || (r_state == ACK) || (r_state == WAIT_IDLE);
  assign done    = (r_state == DONE);
  assign busy    = (r_state != IDLE) && (r_state != DONE);
  assign ack_ok  = done & r_ack;
  assign timeout = done & r_to;
  assign ps_clock_oe = r_clk_oe;
  assign ps_data_oe  = r_dat_oe;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_clk_s    <= 2'b11;
      r_dat_s    <= 2'b11;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_s    <= {r_clk_s[0], ps_clock_in};
      r_dat_s    <= {r_dat_s[0], ps_data_in};
      r_clk_prev <= w_clk_f;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_tcnt   <= '0;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_ack    <= 1'b0;
      r_to     <= 1'b0;
      r_clk_oe <= 1'b0;
      r_dat_oe <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_cnt    <= w_cnt_n;
      r_tcnt   <= w_tcnt_n;
      r_shift  <= w_shift_n;
      r_bitcnt <= w_bitcnt_n;
      r_ack    <= w_ack_n;
      r_to     <= w_to_n;
      r_clk_oe <= w_clk_oe_n;
      r_dat_oe <= w_dat_oe_n;
    end
  end
  always_comb begin
    w_state_n  = r_state;
    w_cnt_n    = r_cnt;
    w_tcnt_n   = w_tick ? (w_fall ? '0 : r_tcnt + TW'(1)) : r_tcnt;
    w_shift_n  = r_shift;
    w_bitcnt_n = r_bitcnt;
    w_ack_n    = r_ack;
    w_to_n     = r_to;
    w_clk_oe_n = r_clk_oe;
    w_dat_oe_n = r_dat_oe;
    case (r_state)
      IDLE: if (start) begin
        w_shift_n  = {1'b1, ~^tx_data, tx_data};
        w_cnt_n    = '0;
        w_ack_n    = 1'b0;
        w_to_n     = 1'b0;
        w_clk_oe_n = 1'b1;
        w_state_n  = INHIBIT;
      end
      INHIBIT: begin
        w_cnt_n = r_cnt + CW'(1);
        // start bit is already low during the last inhibit cycle, before the clock is released
        if (r_cnt == CW'(INHIBIT_CYCLES - 2) || r_cnt == CW'(INHIBIT_CYCLES - 1)) w_dat_oe_n = 1'b1;
        if (r_cnt == CW'(INHIBIT_CYCLES - 1)) begin
          w_clk_oe_n = 1'b0;
          w_tcnt_n   = '0;
          w_state_n  = RTS;
        end
      end
      RTS: if (w_fall) begin
        w_dat_oe_n = ~r_shift[0];
        w_shift_n  = r_shift >> 1;
        w_bitcnt_n = 4'd1;
        w_state_n  = BITS;
      end
      BITS: if (w_fall) begin
        w_dat_oe_n = ~r_shift[0];
        w_shift_n  = r_shift >> 1;
        w_bitcnt_n = r_bitcnt + 4'd1;
        if (r_bitcnt == 4'd9) w_state_n = ACK;
      end
      ACK: if (w_fall) begin
        w_ack_n   = ~r_dat_s[1];
        w_state_n = WAIT_IDLE;
      end
      WAIT_IDLE: if (w_clk_f && r_dat_s[1]) w_state_n = DONE;
      DONE: w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
    // normal completion wins over a timeout in the same cycle
    if (w_tick && !w_fall && r_tcnt == TW'(TIMEOUT_CYCLES - 1) && w_state_n != DONE) begin
      w_clk_oe_n = 1'b0;
      w_dat_oe_n = 1'b0;
      w_ack_n    = 1'b0;
      w_to_n     = 1'b1;
      w_state_n  = DONE;
    end
  end
endmodule

// File: tb/tb_ps2_tx.sv
// tb_ps2_tx: randomized self-checking bench for ps2_tx with a behavioural PS/2 device
module tb_ps2_tx;
  localparam int I  = 100;
  localparam int T  = 2000;
  localparam int F  = 8;
  localparam int HP = 25;
`ifdef PS2_TX_FILTER_EN
  localparam int LAT = 3 + F;
`else
  localparam int LAT = 3;
`endif
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       busy, done, ack_ok, timeout, ps_clock_oe, ps_data_oe;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       ps_clock_in, ps_data_in;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_err = 0;
  int         n_done = 0;
  int         rts_cyc = 0;
  int         last_fall = 0;
  assign ps_clock_in = dev_clk & ~ps_clock_oe;
  assign ps_data_in  = dev_dat & ~ps_data_oe;
  ps2_tx #(.INHIBIT_CYCLES(I), .TIMEOUT_CYCLES(T), .FILTER_LEN(F)) dut (
    .clock(clock), .reset(reset), .start(start), .tx_data(tx_data),
    .busy(busy), .done(done), .ack_ok(ack_ok), .timeout(timeout),
    .ps_clock_in(ps_clock_in), .ps_data_in(ps_data_in),
    .ps_clock_oe(ps_clock_oe), .ps_data_oe(ps_data_oe)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) if (done) n_done = n_done + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [9:0] frame(input logic [7:0] d);
    return {1'b1, ($countones(d) % 2 == 0), d};
  endfunction
  task automatic send(input logic [7:0] d, input bit poke);
    int n, dn, dpos;
    n = 0; dn = 0; dpos = 0;
    @(negedge clock);
    start = 1'b1;
    tx_data = d;
    @(negedge clock);
    start = 1'b0;
    chk("busy_on", busy, 1);
    while (ps_clock_oe === 1'b1 && n < 4 * I) begin
      n++;
      if (ps_data_oe) begin dn++; dpos = n; end
      start = poke && (n == I / 2);
      if (poke) tx_data = 8'hFF;
      @(negedge clock);
    end
    start = 1'b0;
    chk("inhibit_len", n, I);
    chk("start_bit_cnt", dn, 1);
    chk("start_bit_pos", dpos, I);
    chk("rts_data_oe", ps_data_oe, 1);
    rts_cyc = cyc;
  endtask
  task automatic device(input int n, input bit ack, input bit glitch, output logic [10:0] smp);
    smp = '1;
    repeat (HP) @(negedge clock);
    for (int k = 1; k <= n; k++) begin
      dev_clk = 1'b0;
      last_fall = cyc;
      repeat (HP) @(negedge clock);
      dev_clk = 1'b1;
      smp[k-1] = ps_data_in;
      if (k == 10 && ack) dev_dat = 1'b0;
      if (k == 11) dev_dat = 1'b1;
      if (glitch && k == 3) begin
        repeat (5) @(negedge clock);
        dev_clk = 1'b0;
        repeat (3) @(negedge clock);
        dev_clk = 1'b1;
      end
      if (k < n) repeat (HP) @(negedge clock);
    end
  endtask
  task automatic finish_tx(input bit ea, input bit et, input bit poke, output int dcyc);
    for (int i = 0; i < 3 * T && !done; i++) @(negedge clock);
    dcyc = cyc;
    chk("done_seen", done, 1);
    chk("ack_ok", ack_ok, ea);
    chk("timeout", timeout, et);
    chk("busy_at_done", busy, 0);
    chk("clk_oe_at_done", ps_clock_oe, 0);
    chk("dat_oe_at_done", ps_data_oe, 0);
    if (poke) begin
      start = 1'b1;
      tx_data = 8'hFF;
    end
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    chk("idle_after", {busy, ps_clock_oe, ps_data_oe}, 0);
  endtask
  initial begin
    logic [10:0] smp;
    logic [7:0]  d;
    bit          a;
    int          dc, nd0;
    repeat (3) @(negedge clock);
    chk("rst_outs", {busy, done, ack_ok, timeout, ps_clock_oe, ps_data_oe}, 0);
    reset = 1'b0;
    @(negedge clock);
    chk("idle_outs", {busy, done, ps_clock_oe, ps_data_oe}, 0);
    nd0 = n_done;
    send(8'hED, 0);
    device(11, 1, 0, smp);
    chk("ed_frame", smp[9:0], 10'h3ED);
    finish_tx(1, 0, 0, dc);
    chk("ed_one_done", n_done - nd0, 1);
    send(8'h00, 0);
    device(11, 0, 0, smp);
    chk("zero_frame", smp[9:0], frame(8'h00));
    finish_tx(0, 0, 0, dc);
    for (int r = 0; r < 6; r++) begin
      d = 8'($urandom);
      a = 1'($urandom_range(0, 1));
      send(d, 0);
      device(11, a, 0, smp);
      chk("rnd_frame", smp[9:0], frame(d));
      finish_tx(a, 0, 0, dc);
    end
    send(8'hA5, 0);
    finish_tx(0, 1, 0, dc);
    chk("to_rts_lat", dc - rts_cyc, T);
    send(8'h3C, 0);
    device(4, 0, 0, smp);
    chk("part_bits", smp[3:0], 4'hC);
    finish_tx(0, 1, 0, dc);
    chk("to_fall_lat", dc - last_fall, LAT + T);
    nd0 = n_done;
    send(8'h5A, 1);
    device(11, 1, 0, smp);
    chk("poke_frame", smp[9:0], frame(8'h5A));
    finish_tx(1, 0, 1, dc);
    repeat (3) @(negedge clock);
    chk("poke_one_done", n_done - nd0, 1);
    nd0 = n_done;
    send(8'hC3, 0);
    device(3, 0, 0, smp);
    chk("pre_rst_busy", {busy, ps_data_oe}, 2'b11);
    reset = 1'b1;
    @(negedge clock);
    chk("mid_rst", {busy, done, ps_clock_oe, ps_data_oe}, 0);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    chk("rst_no_done", n_done - nd0, 0);
`ifdef PS2_TX_FILTER_EN
    send(8'h96, 0);
    device(11, 1, 1, smp);
    chk("glitch_frame", smp[9:0], frame(8'h96));
    finish_tx(1, 0, 0, dc);
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
